audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_sample_fifo.sv | 138 +++++++++++++
 tb/tb_audio_sample_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample FIFO that tags IEC60958 channel-status block starts.
// Latency: first-word-fall-through, push-to-valid 1 cycle, no same-cycle bypass.
// Backpressure: sample_ready holds the head; strobes into a full FIFO are dropped and flagged.
//
// Ports:
//   clk, reset_n                 single clock, async active-low reset
//   audio_stb, audio_l, audio_r  producer strobe and stereo sample
//   sample_valid/ready           consumer handshake on the head entry
//   sample_l, sample_r           head entry data (0 when empty)
//   sample_bstart                head entry is frame 0 of a channel-status block
//   level                        current entry count, 0..DEPTH
//   overflow, clear_ovf          sticky drop flag and its clear
module audio_sample_fifo #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int BLOCK_FRAMES = 192
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_stb,
    input  logic [WIDTH-1:0]         audio_l,
    input  logic [WIDTH-1:0]         audio_r,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic [WIDTH-1:0]         sample_l,
    output logic [WIDTH-1:0]         sample_r,
    output logic                     sample_bstart,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clear_ovf
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int FCW = (BLOCK_FRAMES > 1) ? $clog2(BLOCK_FRAMES) : 1;
    localparam int EW  = 2 * WIDTH + 1;

    localparam logic [LW-1:0]  FULL_LVL   = LW'(DEPTH);
    localparam logic [FCW-1:0] LAST_FRAME = FCW'(BLOCK_FRAMES - 1);

    // Entry layout: {bstart, left, right}
    logic [EW-1:0]  mem_q [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q,  level_d;
    logic [FCW-1:0] frame_q,  frame_d;
    logic           ovf_q,    ovf_d;

    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    logic           drop;
    logic [EW-1:0]  head;

    // Handshake decode. Pop depends only on registered state, so a push
    // into an empty FIFO can never be popped on the same edge. A full FIFO
    // accepts a strobe only when the head leaves on that same edge.
    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);
        pop   = !empty && sample_ready;
        push  = audio_stb && (!full || pop);
        drop  = audio_stb && full && !pop;
    end

    // Next-state logic. DEPTH is a power of two, so pointers wrap by
    // natural overflow of their AW-bit width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        frame_d  = frame_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The frame counter only moves on accepted pushes, so dropped
        // strobes leave no hole in the delivered block sequence.
        if (push) begin
            frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + FCW'(1);
        end

        // A drop on the same edge as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frame_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: every output derived from it is gated by
    // level, which resets asynchronously, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {(frame_q == '0), audio_l, audio_r};
        end
    end

    always_comb begin
        head          = mem_q[rd_ptr_q];
        sample_valid  = !empty;
        sample_bstart = empty ? 1'b0 : head[EW-1];
        sample_l      = empty ? '0   : head[2*WIDTH-1:WIDTH];
        sample_r      = empty ? '0   : head[WIDTH-1:0];
        level         = level_q;
        overflow      = ovf_q;
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int BF    = 192;

    logic              clk;
    logic              reset_n;
    logic              audio_stb;
    logic [WIDTH-1:0]  audio_l;
    logic [WIDTH-1:0]  audio_r;
    logic              sample_valid;
    logic              sample_ready;
    logic [WIDTH-1:0]  sample_l;
    logic [WIDTH-1:0]  sample_r;
    logic              sample_bstart;
    logic [3:0]        level;
    logic              overflow;
    logic              clear_ovf;

    audio_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BLOCK_FRAMES(BF)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_stb    (audio_stb),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_bstart(sample_bstart),
        .level        (level),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of delivered entries, a running
    // count of accepted samples, and the sticky drop flag.
    typedef struct packed {
        bit        b;
        bit [15:0] l;
        bit [15:0] r;
    } ent_t;

    ent_t mq[$];
    int   accepted;
    bit   m_ovf;

    int n_tests;
    int n_fail;

    // Block-start tracking for the long streaming run.
    bit bs_track;
    int pop_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("valid",    32'(sample_valid),  32'(mq.size() != 0));
        chk("level",    32'(level),         32'(mq.size()));
        chk("overflow", 32'(overflow),      32'(m_ovf));
        chk("head_l",   32'(sample_l),      32'(h.l));
        chk("head_r",   32'(sample_r),      32'(h.r));
        chk("bstart",   32'(sample_bstart), 32'(h.b));
    endtask

    // One clock: drive at the falling edge, let the rising edge act,
    // update the model, compare at the next falling edge.
    task automatic step(input bit stb, input logic [15:0] l, input logic [15:0] r,
                        input bit rdy, input bit clr);
        bit pop, push, drop, full;
        audio_stb    = stb;
        audio_l      = l;
        audio_r      = r;
        sample_ready = rdy;
        clear_ovf    = clr;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() != 0) && rdy;
        push = stb && (!full || pop);
        drop = stb && full && !pop;
        if (bs_track && pop) begin
            pop_idx++;
            chk("bstart_seq", 32'(sample_bstart),
                32'(pop_idx == 1 || pop_idx == 193 || pop_idx == 385));
        end
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back('{b: ((accepted % BF) == 0), l: l, r: r});
            accepted++;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear
    // before any clock edge arrives.
    task automatic pulse_reset();
        audio_stb = 1'b0; sample_ready = 1'b0; clear_ovf = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_level", 32'(level),         32'd0);
        chk("rst_valid", 32'(sample_valid),  32'd0);
        chk("rst_l",     32'(sample_l),      32'd0);
        chk("rst_r",     32'(sample_r),      32'd0);
        chk("rst_bst",   32'(sample_bstart), 32'd0);
        chk("rst_ovf",   32'(overflow),      32'd0);
        mq.delete();
        accepted = 0;
        m_ovf    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        accepted = 0; m_ovf = 1'b0;
        bs_track = 1'b0; pop_idx = 0;
        reset_n = 1'b0; audio_stb = 1'b0; audio_l = '0; audio_r = '0;
        sample_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        @(negedge clk);
        check_all();

        // Single strobe: visible one cycle later with bstart set.
        step(1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0);
        chk("t1_valid",  32'(sample_valid),  32'd1);
        chk("t1_l",      32'(sample_l),      32'h1234);
        chk("t1_r",      32'(sample_r),      32'hABCD);
        chk("t1_bstart", 32'(sample_bstart), 32'd1);
        chk("t1_level",  32'(level),         32'd1);

        // Nine strobes into a stalled FIFO: ninth dropped.
        pulse_reset();
        for (int i = 1; i <= 9; i++)
            step(1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, 1'b0);
        chk("full_level", 32'(level),    32'd8);
        chk("full_ovf",   32'(overflow), 32'd1);
        chk("full_headl", 32'(sample_l), 32'h1001);
        chk("full_headr", 32'(sample_r), 32'h2001);

        // Clear, then strobe + pop on the same edge while full.
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0);
        chk("pp_level", 32'(level),    32'd8);
        chk("pp_ovf",   32'(overflow), 32'd0);
        chk("pp_head",  32'(sample_l), 32'h1002);
        for (int i = 0; i < 7; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("pp_tail_l", 32'(sample_l), 32'h5555);
        chk("pp_tail_r", 32'(sample_r), 32'h6666);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("drained", 32'(sample_valid), 32'd0);

        // Clear colliding with another drop keeps the flag; idle clear drops it.
        for (int i = 0; i < 9; i++) step(1'b1, 16'(i), 16'(i), 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1);
        chk("ovf_setwins", 32'(overflow), 32'd1);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Streaming 385 samples: block starts on samples 1, 193, 385.
        pulse_reset();
        bs_track = 1'b1; pop_idx = 0;
        for (int i = 0; i < 385; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        bs_track = 1'b0;
        chk("stream_count", 32'(pop_idx), 32'd385);

        // Reset with five entries queued mid-stream.
        for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd5);
        pulse_reset();
        step(1'b1, 16'h0BAD, 16'hF00D, 1'b0, 1'b0);
        chk("post_rst_bst", 32'(sample_bstart), 32'd1);

        // Randomised phases with varying producer/consumer rates.
        for (int ph = 0; ph < 24; ph++) begin
            int sp, rp;
            sp = $urandom_range(10, 100);
            rp = $urandom_range(0, 100);
            for (int c = 0; c < 80; c++)
                step(($urandom_range(0, 99) < sp), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 99) < rp), ($urandom_range(0, 15) == 0));
            if (ph == 12) pulse_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
